microbot_motor_driver: RTL and testbench
========================================

MICROBOT_MOTOR_DRIVER -- requirements
Module: microbot_motor_driver

Interface
REQ-001 SHALL have parameter DEADTIME, default 4: cycles both H-bridge legs of a motor are held low before driving a new direction; range 1..255.
REQ-002 SHALL have parameter RAMP_DIV, default 16: cycles per +1 PWM level step while ramping up; range 1..65535.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port enable  input  1  1 = drive allowed; 0 = both motors forced OFF.
REQ-006 SHALL have port cmd  input  4  motor polarization command: [3] A right, [2] A left, [1] B right, [0] B left.
REQ-007 SHALL have port duty  input  4  target PWM level 0..15, shared by both motors.
REQ-008 SHALL have port clear_fault  input  1  one-cycle pulse clears both fault bits.
REQ-009 SHALL have port hbridge  output  4  registered gated leg drives, same bit mapping as cmd.
REQ-010 SHALL have port running  output  2  [1] motor A in RUN, [0] motor B in RUN.
REQ-011 SHALL have port fault  output  2  sticky illegal-command flags, [1] A, [0] B.

Function
REQ-012 SHALL run one free-running 4-bit PWM counter, 0..15, wrapping 15->0 (period 16), shared by both motors.
REQ-013 SHALL give each motor an independent FSM with states OFF, DEAD, RUN.
REQ-014 SHALL decode each motor's 2-bit command: 00 coast, 10 right, 01 left, 11 illegal.
REQ-015 SHALL, in OFF, drive both legs low with level 0; on right/left, latch the direction and go to DEAD.
REQ-016 SHALL, in DEAD, hold both legs low for exactly DEADTIME cycles, then enter RUN with level 0.
REQ-017 SHALL, in DEAD, go to OFF on coast; on the opposite direction, latch it and restart the DEADTIME count.
REQ-018 SHALL, in RUN, drive the latched-direction leg high when pwm_counter < level; the other leg is always low.
REQ-019 SHALL, in RUN, increment level by 1 every RAMP_DIV cycles while level < duty.
REQ-020 SHALL, in RUN, set level to duty on the next edge when duty < level; no ramp-down.
REQ-021 SHALL, in RUN, go to OFF on coast; on the opposite direction, go to DEAD with the new direction latched and level reset to 0.
REQ-022 SHALL, on an illegal command (11) in any state, go to OFF and set that motor's fault bit.
REQ-023 SHALL keep a fault bit set until clear_fault or reset; an illegal command coincident with clear_fault leaves the bit set.
REQ-024 SHALL force both FSMs to OFF on the edge where enable is sampled 0; enable has priority over cmd.
REQ-025 SHALL update hbridge on the same edge as the FSM transition, one cycle after cmd is sampled.
REQ-026 SHALL never assert both legs of one motor in the same cycle, under any input sequence.
REQ-027 SHALL assert running[x] exactly while motor x's FSM is in RUN.

Reset
REQ-028 SHALL, while reset is sampled high, set both FSMs to OFF, both levels to 0, pwm_counter 0, hbridge 4'b0000, running 2'b00 and fault 2'b00; reset overrides all other inputs.
REQ-029 SHALL apply reset mid-DEAD or mid-RUN with no residual count, level or direction.

Structure
REQ-030 SHALL place in shared package microbot_pkg: the FSM state encoding, cmd field positions (A = [3:2], B = [1:0]), the coast/right/left/illegal encodings, and the DEADTIME/RAMP_DIV defaults.
REQ-031 SHALL implement one motor (FSM, dead-time counter, ramp counter, level, fault bit) in sub-module motor_channel, instantiated twice; the PWM counter SHALL live in the top level.

Verification (DEADTIME=4, RAMP_DIV=16)
REQ-032 SHALL check reset: reset=1 for 2 cycles with cmd=4'b1111 -> hbridge=0, running=0, fault=0.
REQ-033 SHALL check ramp: enable=1, duty=15, cmd=4'b1010 -> hbridge=0 for 4 cycles; running=2'b11; level reaches 15 after 240 RUN cycles; then bits [3],[1] are high 15 of 16 cycles and [2],[0] stay 0.
REQ-034 SHALL check reversal: A at level 15, cmd 1010->0110 -> hbridge[3]=0 the next edge; hbridge[2]=0 for 4 DEAD cycles; A then ramps from level 0; B is undisturbed.
REQ-035 SHALL check fault: cmd[1:0]=11 -> B goes OFF, fault=2'b01 persists after cmd=00 until a clear_fault pulse, then fault=2'b00.
REQ-036 SHALL check enable: enable=0 mid-ramp -> hbridge=0 and running=0 on the next edge; enable=1 again -> a new 4-cycle DEAD before any drive.
REQ-037 SHALL check duty drop: in RUN at level 15, duty=5 -> level=5 the next edge, giving 5-of-16 high cycles.

Source files
------------

// File: rtl/microbot_pkg.sv
// Shared definitions for the microbot two-motor H-bridge driver: state encoding,
// command field positions, command encodings and parameter defaults.
package microbot_pkg;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_DEAD = 2'd1,
        ST_RUN  = 2'd2
    } motor_state_t;

    // Command field positions inside the 4-bit cmd bus.
    localparam int CMD_A_HI = 3;
    localparam int CMD_A_LO = 2;
    localparam int CMD_B_HI = 1;
    localparam int CMD_B_LO = 0;

    localparam logic [1:0] CMD_COAST   = 2'b00;
    localparam logic [1:0] CMD_RIGHT   = 2'b10;
    localparam logic [1:0] CMD_LEFT    = 2'b01;
    localparam logic [1:0] CMD_ILLEGAL = 2'b11;

    localparam int unsigned DEADTIME_DEFAULT = 4;
    localparam int unsigned RAMP_DIV_DEFAULT = 16;

    localparam int PWM_W = 4;

endpackage

// File: rtl/microbot_motor_driver_channel.sv
// One motor: OFF/DEAD/RUN state machine, dead-time counter, ramp counter,
// PWM level and sticky fault bit. Leg drives are registered.
module motor_channel
    import microbot_pkg::*;
#(
    parameter int unsigned DEADTIME = DEADTIME_DEFAULT,
    parameter int unsigned RAMP_DIV = RAMP_DIV_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [1:0]         cmd,
    input  logic [PWM_W-1:0]   duty,
    input  logic [PWM_W-1:0]   pwm_next,
    input  logic               clear_fault,
    output logic [1:0]         legs,
    output motor_state_t       state,
    output logic               fault
);

    localparam logic [7:0]  DEAD_LOAD = 8'(DEADTIME - 1);
    localparam logic [15:0] RAMP_LAST = 16'(RAMP_DIV - 1);

    motor_state_t     state_n;
    logic [1:0]       dir, dir_n;
    logic [PWM_W-1:0] level, level_n;
    logic [7:0]       dead_cnt, dead_n;
    logic [15:0]      ramp_cnt, ramp_n;
    logic             fault_n;
    logic [1:0]       legs_n;

    always_comb begin
        state_n = state;
        dir_n   = dir;
        level_n = level;
        dead_n  = dead_cnt;
        ramp_n  = ramp_cnt;
        fault_n = fault & ~clear_fault;
        if (!enable) begin
            state_n = ST_OFF;
            level_n = '0;
        end else if (cmd == CMD_ILLEGAL) begin
            state_n = ST_OFF;
            level_n = '0;
            fault_n = 1'b1;
        end else begin
            case (state)
                ST_OFF: begin
                    level_n = '0;
                    if (cmd != CMD_COAST) begin
                        dir_n   = cmd;
                        dead_n  = DEAD_LOAD;
                        state_n = ST_DEAD;
                    end
                end
                ST_DEAD: begin
                    if (cmd == CMD_COAST) begin
                        state_n = ST_OFF;
                    end else if (cmd != dir) begin
                        dir_n  = cmd;
                        dead_n = DEAD_LOAD;
                    end else if (dead_cnt == 8'd0) begin
                        state_n = ST_RUN;
                        level_n = '0;
                        ramp_n  = '0;
                    end else begin
                        dead_n = dead_cnt - 8'd1;
                    end
                end
                ST_RUN: begin
                    if (cmd == CMD_COAST) begin
                        state_n = ST_OFF;
                        level_n = '0;
                    end else if (cmd != dir) begin
                        state_n = ST_DEAD;
                        dir_n   = cmd;
                        level_n = '0;
                        dead_n  = DEAD_LOAD;
                    end else if (duty < level) begin
                        // Instant ramp-down; the ramp timer restarts from the new level.
                        level_n = duty;
                        ramp_n  = '0;
                    end else if (level < duty) begin
                        if (ramp_cnt == RAMP_LAST) begin
                            level_n = level + 1'b1;
                            ramp_n  = '0;
                        end else begin
                            ramp_n = ramp_cnt + 16'd1;
                        end
                    end else begin
                        ramp_n = '0;
                    end
                end
                default: state_n = ST_OFF;
            endcase
        end
    end

    // Legs are computed from next-cycle state and PWM count so the register shows
    // the drive belonging to the cycle it is visible in. dir is only ever 10 or 01.
    always_comb begin
        legs_n = 2'b00;
        if (state_n == ST_RUN && pwm_next < level_n) begin
            legs_n = dir_n;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_OFF;
            dir      <= 2'b00;
            level    <= '0;
            dead_cnt <= '0;
            ramp_cnt <= '0;
            fault    <= 1'b0;
            legs     <= 2'b00;
        end else begin
            state    <= state_n;
            dir      <= dir_n;
            level    <= level_n;
            dead_cnt <= dead_n;
            ramp_cnt <= ramp_n;
            fault    <= fault_n;
            legs     <= legs_n;
        end
    end

endmodule

// File: rtl/microbot_motor_driver.sv
// Two-motor H-bridge driver top: shared free-running PWM counter and two
// motor_channel instances (A on the upper cmd/hbridge bits, B on the lower).
module microbot_motor_driver
    import microbot_pkg::*;
#(
    parameter int unsigned DEADTIME = DEADTIME_DEFAULT,
    parameter int unsigned RAMP_DIV = RAMP_DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] cmd,
    input  logic [3:0] duty,
    input  logic       clear_fault,
    output logic [3:0] hbridge,
    output logic [1:0] running,
    output logic [1:0] fault
);

    logic [PWM_W-1:0] pwm_cnt;
    logic [PWM_W-1:0] pwm_next;
    motor_state_t     state_a;
    motor_state_t     state_b;

    assign pwm_next = pwm_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_next;
        end
    end

    motor_channel #(.DEADTIME(DEADTIME), .RAMP_DIV(RAMP_DIV)) u_motor_a (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .cmd         (cmd[CMD_A_HI:CMD_A_LO]),
        .duty        (duty),
        .pwm_next    (pwm_next),
        .clear_fault (clear_fault),
        .legs        (hbridge[CMD_A_HI:CMD_A_LO]),
        .state       (state_a),
        .fault       (fault[1])
    );

    motor_channel #(.DEADTIME(DEADTIME), .RAMP_DIV(RAMP_DIV)) u_motor_b (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .cmd         (cmd[CMD_B_HI:CMD_B_LO]),
        .duty        (duty),
        .pwm_next    (pwm_next),
        .clear_fault (clear_fault),
        .legs        (hbridge[CMD_B_HI:CMD_B_LO]),
        .state       (state_b),
        .fault       (fault[0])
    );

    assign running = {state_a == ST_RUN, state_b == ST_RUN};

endmodule

// File: tb/tb_microbot_motor_driver.sv
// Bench for microbot_motor_driver: directed scenarios with literal expectations,
// then randomized traffic, all compared each cycle against a behavioural model.
module tb_microbot_motor_driver;

    localparam int DT = 4;
    localparam int RD = 16;
    localparam int M_OFF = 0, M_DEAD = 1, M_RUN = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [3:0] cmd;
    logic [3:0] duty;
    logic       clear_fault;
    logic [3:0] hbridge;
    logic [1:0] running;
    logic [1:0] fault;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Model state, indexed 1 = motor A, 0 = motor B.
    int m_st[2], m_dir[2], m_lvl[2], m_dead[2], m_age[2], m_flt[2];
    int m_pwm;

    always #5 clk = ~clk;

    microbot_motor_driver #(.DEADTIME(DT), .RAMP_DIV(RD)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .cmd         (cmd),
        .duty        (duty),
        .clear_fault (clear_fault),
        .hbridge     (hbridge),
        .running     (running),
        .fault       (fault)
    );

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: per motor, what the spec says happens at each edge.
    always @(posedge clk) begin
        int c;
        if (reset) begin
            m_pwm = 0;
            for (int m = 0; m < 2; m++) begin
                m_st[m] = M_OFF; m_dir[m] = 0; m_lvl[m] = 0;
                m_dead[m] = 0; m_age[m] = 0; m_flt[m] = 0;
            end
        end else begin
            m_pwm = (m_pwm + 1) % 16;
            for (int m = 0; m < 2; m++) begin
                c = (m == 1) ? int'(cmd[3:2]) : int'(cmd[1:0]);
                if (clear_fault) m_flt[m] = 0;
                if (!enable) begin
                    m_st[m] = M_OFF; m_lvl[m] = 0;
                end else if (c == 3) begin
                    m_st[m] = M_OFF; m_lvl[m] = 0; m_flt[m] = 1;
                end else if (c == 0) begin
                    m_st[m] = M_OFF; m_lvl[m] = 0;
                end else if (m_st[m] == M_OFF || c != m_dir[m]) begin
                    m_st[m] = M_DEAD; m_dir[m] = c; m_lvl[m] = 0; m_dead[m] = 0;
                end else if (m_st[m] == M_DEAD) begin
                    m_dead[m]++;
                    if (m_dead[m] == DT) begin
                        m_st[m] = M_RUN; m_lvl[m] = 0; m_age[m] = 0;
                    end
                end else begin
                    if (int'(duty) < m_lvl[m]) begin
                        m_lvl[m] = int'(duty); m_age[m] = 0;
                    end else if (m_lvl[m] < int'(duty)) begin
                        m_age[m]++;
                        if (m_age[m] == RD) begin
                            m_lvl[m]++; m_age[m] = 0;
                        end
                    end else begin
                        m_age[m] = 0;
                    end
                end
            end
        end
    end

    function automatic int exp_legs(input int m);
        return (m_st[m] == M_RUN && m_pwm < m_lvl[m]) ? m_dir[m] : 0;
    endfunction

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("hbridge", int'(hbridge), exp_legs(1) * 4 + exp_legs(0));
            check("running", int'(running), (m_st[1] == M_RUN ? 2 : 0) + (m_st[0] == M_RUN ? 1 : 0));
            check("fault", int'(fault), m_flt[1] * 2 + m_flt[0]);
            check("legs_exclusive", int'((hbridge[3] & hbridge[2]) | (hbridge[1] & hbridge[0])), 0);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Counts high cycles of one hbridge bit over one PWM period.
    task automatic count_high(input int bit_idx, output int hi);
        hi = 0;
        for (int i = 0; i < 16; i++) begin
            step(1);
            if (hbridge[bit_idx]) hi++;
        end
    endtask

    initial begin
        int hi;
        reset = 1'b1; enable = 1'b1; cmd = 4'b1111; duty = 4'd15; clear_fault = 1'b0;
        step(2);
        chk_en = 1'b1;
        check("reset_hbridge", int'(hbridge), 0);
        check("reset_running", int'(running), 0);
        check("reset_fault", int'(fault), 0);
        reset = 1'b0; cmd = 4'b0000;
        step(2);

        // Ramp: both motors right.
        cmd = 4'b1010;
        for (int i = 0; i < DT; i++) begin
            step(1);
            check("dead_hbridge", int'(hbridge), 0);
        end
        step(1);
        check("ramp_running", int'(running), 3);
        step(240);
        check("ramp_model_level", m_lvl[1], 15);
        count_high(3, hi); check("ramp_a_high", hi, 15);
        count_high(1, hi); check("ramp_b_high", hi, 15);
        check("ramp_left_legs", int'({hbridge[2], hbridge[0]}), 0);

        // Reversal of A only.
        cmd = 4'b0110;
        step(1);
        check("rev_a_right_off", int'(hbridge[3]), 0);
        for (int i = 1; i < DT; i++) begin
            step(1);
            check("rev_a_left_dead", int'(hbridge[2]), 0);
        end
        step(1);
        check("rev_running", int'(running), 3);
        check("rev_model_level", m_lvl[1], 0);
        count_high(1, hi); check("rev_b_undisturbed", hi, 15);

        // Fault on B.
        cmd = 4'b0111;
        step(1);
        check("fault_set", int'(fault), 1);
        check("fault_b_off", int'(running[0]), 0);
        cmd = 4'b0100;
        step(3);
        check("fault_sticky", int'(fault), 1);
        clear_fault = 1'b1;
        step(1);
        clear_fault = 1'b0;
        check("fault_cleared", int'(fault), 0);

        // Enable drop mid-ramp.
        cmd = 4'b0101;
        step(40);
        enable = 1'b0;
        step(1);
        check("en_hbridge", int'(hbridge), 0);
        check("en_running", int'(running), 0);
        enable = 1'b1;
        for (int i = 0; i < DT; i++) begin
            step(1);
            check("en_dead_hbridge", int'(hbridge), 0);
        end
        step(1);
        check("en_rerun", int'(running), 3);

        // Duty drop from level 15.
        step(240);
        check("drop_model_pre", m_lvl[1], 15);
        duty = 4'd5;
        step(1);
        check("drop_model_level", m_lvl[1], 5);
        count_high(2, hi); check("drop_a_high", hi, 5);

        // Randomized traffic.
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(0, 7) == 0) cmd = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 63) == 0) duty = 4'($urandom_range(0, 15));
            enable = ($urandom_range(0, 99) != 0);
            clear_fault = ($urandom_range(0, 15) == 0);
            reset = ($urandom_range(0, 599) == 0);
            step(1);
        end
        reset = 1'b0; clear_fault = 1'b0;
        step(2);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
